// File: rtl/argmax_classifier_if.sv
// Result/score port bundle for argmax_classifier; the DUT uses the slave modport.
// Threshold signals exist only when ARGMAX_THRESHOLD_EN is defined.
interface argmax_classifier_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 2,
  parameter int DROP_WIDTH  = 8
);
  localparam int IDX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                         scores_ready;
  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES];
  logic                         result_valid;
  logic                         result_ready;
  logic [IDX_WIDTH-1:0]         class_index;
  logic signed [DATA_WIDTH-1:0] max_score;
  logic                         busy;
  logic [DROP_WIDTH-1:0]        drop_count;

`ifdef ARGMAX_THRESHOLD_EN
  logic signed [DATA_WIDTH-1:0] threshold;
  logic                         below_threshold;

  modport slave (
    input  scores_ready, scores, result_ready, threshold,
    output result_valid, class_index, max_score, busy, drop_count, below_threshold
  );
  modport master (
    output scores_ready, scores, result_ready, threshold,
    input  result_valid, class_index, max_score, busy, drop_count, below_threshold
  );
`else
  modport slave (
    input  scores_ready, scores, result_ready,
    output result_valid, class_index, max_score, busy, drop_count
  );
  modport master (
    output scores_ready, scores, result_ready,
    input  result_valid, class_index, max_score, busy, drop_count
  );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Serial argmax over one captured score vector, one signed compare per cycle.
// Define ARGMAX_THRESHOLD_EN to add the below_threshold confidence flag.
module argmax_classifier #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 2,
  parameter int DROP_WIDTH  = 8
) (
  input  logic               clock,
  input  logic               reset,
  argmax_classifier_if.slave io
);
  localparam int IDX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_WIDTH-1:0] FIRST_IDX = IDX_WIDTH'((NUM_CLASSES > 1) ? 1 : 0);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                       state_q;
  logic signed [DATA_WIDTH-1:0] buf_q [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_q;
  logic [IDX_WIDTH-1:0]         best_idx_q;
  logic [IDX_WIDTH-1:0]         idx_q;
  logic                         result_valid_q;
  logic                         busy_q;
  logic [DROP_WIDTH-1:0]        drop_q;

  logic                         accept;
  logic                         drop;
  logic                         gt;
  logic signed [DATA_WIDTH-1:0] cand;
  logic signed [DATA_WIDTH-1:0] best_d;
  logic [IDX_WIDTH-1:0]         best_idx_d;
  logic [DROP_WIDTH-1:0]        drop_d;

`ifdef ARGMAX_THRESHOLD_EN
  logic signed [DATA_WIDTH-1:0] thr_q;
  logic                         below_q;
`endif

  function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A single-entry buffer has nothing to walk, so avoid an out-of-range select.
  if (NUM_CLASSES > 1) begin : g_multi
    assign cand = buf_q[idx_q];
  end else begin : g_single
    assign cand = buf_q[0];
  end

  always_comb begin
    accept     = io.scores_ready &&
                 ((state_q == IDLE) || ((state_q == DONE) && io.result_ready));
    drop       = io.scores_ready && !accept;
    drop_d     = drop ? sat_inc(drop_q) : drop_q;
    gt         = cand > best_q;
    best_d     = gt ? cand : best_q;
    best_idx_d = gt ? idx_q : best_idx_q;
  end

  // Capture stage: score buffer (and threshold) carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      buf_q <= io.scores;
`ifdef ARGMAX_THRESHOLD_EN
      thr_q <= io.threshold;
`endif
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      best_q         <= '0;
      best_idx_q     <= '0;
      idx_q          <= '0;
      drop_q         <= '0;
`ifdef ARGMAX_THRESHOLD_EN
      below_q        <= 1'b0;
`endif
    end else begin
      drop_q <= drop_d;
      if (accept) begin
        best_q     <= io.scores[0];
        best_idx_q <= '0;
        idx_q      <= FIRST_IDX;
        busy_q     <= 1'b1;
        if (NUM_CLASSES == 1) begin
          state_q        <= DONE;
          result_valid_q <= 1'b1;
`ifdef ARGMAX_THRESHOLD_EN
          below_q        <= io.scores[0] < io.threshold;
`endif
        end else begin
          state_q        <= SCAN;
          result_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          SCAN: begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q        <= DONE;
              result_valid_q <= 1'b1;
`ifdef ARGMAX_THRESHOLD_EN
              below_q        <= best_d < thr_q;
`endif
            end
          end
          DONE: begin
            if (io.result_ready) begin
              state_q        <= IDLE;
              result_valid_q <= 1'b0;
              busy_q         <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io.result_valid = result_valid_q;
  assign io.class_index  = best_idx_q;
  assign io.max_score    = best_q;
  assign io.busy         = busy_q;
  assign io.drop_count   = drop_q;
`ifdef ARGMAX_THRESHOLD_EN
  assign io.below_threshold = below_q;
`endif

endmodule
